// File: rtl/mdu_issue_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mdu_issue_ctrl_pkg
// Brief    : Instruction codes, FSM states and decode helpers for MDU issue.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_issue_ctrl_pkg;

  localparam logic [7:0] c_INST_NOP   = 8'h00;
  localparam logic [7:0] c_INST_MFHI  = 8'h10;
  localparam logic [7:0] c_INST_MTHI  = 8'h11;
  localparam logic [7:0] c_INST_MFLO  = 8'h12;
  localparam logic [7:0] c_INST_MTLO  = 8'h13;
  localparam logic [7:0] c_INST_MULT  = 8'h18;
  localparam logic [7:0] c_INST_MULTU = 8'h19;
  localparam logic [7:0] c_INST_DIV   = 8'h1A;
  localparam logic [7:0] c_INST_DIVU  = 8'h1B;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_muldiv(input logic [7:0] inst);
    return (inst == c_INST_MULT) || (inst == c_INST_MULTU) ||
           (inst == c_INST_DIV)  || (inst == c_INST_DIVU);
  endfunction

  function automatic logic is_div(input logic [7:0] inst);
    return (inst == c_INST_DIV) || (inst == c_INST_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mdu_issue_ctrl
// Brief    : EX-stage issue/stall control for the multi-cycle mul/div unit,
//            owner of the architectural HI/LO register.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ex_valid,
  input  logic [7:0]  i_inst,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic        i_exception_flush,
  output logic        o_stall_req,
  output logic [7:0]  o_md_inst,
  output logic [31:0] o_md_op1,
  output logic [31:0] o_md_op2,
  output logic        o_md_start,
  output logic        o_md_abort,
  input  logic [63:0] i_md_result,
  input  logic        i_md_done,
  output logic [63:0] o_hilo,
  output logic [31:0] o_mf_result,
  output logic        o_md_timeout
);

  localparam int                  c_WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LIMIT = c_WAIT_W'(MAX_WAIT);

  mdu_state_e          r_state,   w_state_nxt;
  logic [63:0]         r_hilo,    w_hilo_nxt;
  logic [7:0]          r_md_inst, w_md_inst_nxt;
  logic [31:0]         r_md_op1,  w_md_op1_nxt;
  logic [31:0]         r_md_op2,  w_md_op2_nxt;
  logic                r_start,   w_start_nxt;
  logic                r_abort,   w_abort_nxt;
  logic                r_timeout, w_timeout_nxt;
  logic [c_WAIT_W-1:0] r_wait,    w_wait_nxt;
  logic [c_WAIT_W-1:0] w_wait_inc;
  logic                w_accept;
  logic                w_issue;
  logic                w_stall;

  // A divide by zero is never issued; the pipeline simply moves on.
  assign w_accept   = i_ex_valid & ~i_exception_flush;
  assign w_issue    = w_accept & is_muldiv(i_inst) & ~(is_div(i_inst) & (i_op2 == 32'd0));
  assign w_wait_inc = r_wait + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_hilo_nxt    = r_hilo;
    w_md_inst_nxt = r_md_inst;
    w_md_op1_nxt  = r_md_op1;
    w_md_op2_nxt  = r_md_op2;
    w_start_nxt   = 1'b0;
    w_abort_nxt   = 1'b0;
    w_timeout_nxt = r_timeout;
    w_wait_nxt    = r_wait;
    w_stall       = 1'b0;
    case (r_state)
      MDU_IDLE: begin
        w_wait_nxt = '0;
        if (w_issue) begin
          w_md_inst_nxt = i_inst;
          w_md_op1_nxt  = i_op1;
          w_md_op2_nxt  = i_op2;
          w_start_nxt   = 1'b1;
          w_stall       = 1'b1;
          w_state_nxt   = MDU_BUSY;
        end else if (w_accept && (i_inst == c_INST_MTHI)) begin
          w_hilo_nxt[63:32] = i_op1;
        end else if (w_accept && (i_inst == c_INST_MTLO)) begin
          w_hilo_nxt[31:0] = i_op1;
        end
      end
      MDU_BUSY: begin
        w_wait_nxt = w_wait_inc;
        w_stall    = ~i_exception_flush;
        // Flush outranks a coincident done so a killed result never lands.
        if (i_exception_flush) begin
          w_abort_nxt = 1'b1;
          w_state_nxt = MDU_IDLE;
        end else if (i_md_done) begin
          w_hilo_nxt  = i_md_result;
          w_state_nxt = MDU_DONE;
        end else if (w_wait_inc == c_WAIT_LIMIT) begin
          w_timeout_nxt = 1'b1;
          w_abort_nxt   = 1'b1;
          w_state_nxt   = MDU_IDLE;
        end
      end
      MDU_DONE: begin
        w_state_nxt = MDU_IDLE;
      end
      default: begin
        w_state_nxt = MDU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= MDU_IDLE;
      r_hilo    <= '0;
      r_md_inst <= '0;
      r_md_op1  <= '0;
      r_md_op2  <= '0;
      r_start   <= 1'b0;
      r_abort   <= 1'b0;
      r_timeout <= 1'b0;
      r_wait    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_hilo    <= w_hilo_nxt;
      r_md_inst <= w_md_inst_nxt;
      r_md_op1  <= w_md_op1_nxt;
      r_md_op2  <= w_md_op2_nxt;
      r_start   <= w_start_nxt;
      r_abort   <= w_abort_nxt;
      r_timeout <= w_timeout_nxt;
      r_wait    <= w_wait_nxt;
    end
  end

  always_comb begin
    o_mf_result = 32'd0;
    if (i_inst == c_INST_MFHI) begin
      o_mf_result = r_hilo[63:32];
    end else if (i_inst == c_INST_MFLO) begin
      o_mf_result = r_hilo[31:0];
    end
  end

  assign o_stall_req  = w_stall;
  assign o_md_inst    = r_md_inst;
  assign o_md_op1     = r_md_op1;
  assign o_md_op2     = r_md_op2;
  assign o_md_start   = r_start;
  assign o_md_abort   = r_abort;
  assign o_hilo       = r_hilo;
  assign o_md_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mdu_issue_ctrl
// Brief    : Directed scoreboard bench for mdu_issue_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_issue_ctrl;
  import mdu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid, flush, md_done;
  logic [7:0]  inst;
  logic [31:0] op1, op2;
  logic [63:0] md_result;
  logic        stall_req, md_start, md_abort, md_timeout;
  logic [7:0]  md_inst;
  logic [31:0] md_op1, md_op2, mf_result;
  logic [63:0] hilo;

  mdu_issue_ctrl #(.MAX_WAIT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ex_valid(ex_valid), .i_inst(inst), .i_op1(op1), .i_op2(op2),
    .i_exception_flush(flush), .o_stall_req(stall_req),
    .o_md_inst(md_inst), .o_md_op1(md_op1), .o_md_op2(md_op2),
    .o_md_start(md_start), .o_md_abort(md_abort),
    .i_md_result(md_result), .i_md_done(md_done),
    .o_hilo(hilo), .o_mf_result(mf_result), .o_md_timeout(md_timeout)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] inst; logic [31:0] op1; logic [31:0] op2; } start_t;
  typedef struct { logic [63:0] hilo; logic [31:0] mf; logic to; logic [31:0] mdop1; } probe_t;

  start_t start_q[$];
  bit     abort_q[$];
  int     stall_q[$];
  probe_t probe_q[$];
  int     total = 0;
  int     bad = 0;
  logic   probe = 1'b0;
  logic [63:0] exp_hilo;
  logic        exp_to;
  logic [31:0] exp_mdop1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin : monitor
    int     run;
    start_t s;
    probe_t p;
    run = 0;
    forever begin
      @(negedge clk);
      if (md_start === 1'b1) begin
        if (start_q.size() == 0) check("unexp_start", md_start, 0);
        else begin
          s = start_q.pop_front();
          check("start_inst", md_inst, s.inst);
          check("start_op1", md_op1, s.op1);
          check("start_op2", md_op2, s.op2);
        end
      end
      if (md_abort === 1'b1) begin
        if (abort_q.size() == 0) check("unexp_abort", md_abort, 0);
        else check("abort_timeout", md_timeout, abort_q.pop_front());
      end
      if (stall_req === 1'b1) run++;
      else if (run > 0) begin
        if (stall_q.size() == 0) check("unexp_stall_run", run, 0);
        else check("stall_len", run, stall_q.pop_front());
        run = 0;
      end
      if (probe && probe_q.size() > 0) begin
        p = probe_q.pop_front();
        check("hilo", hilo, p.hilo);
        check("mf_result", mf_result, p.mf);
        check("timeout", md_timeout, p.to);
        check("md_op1", md_op1, p.mdop1);
        check("stall_probe", stall_req, 0);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; inst = c_INST_NOP; op1 = '0; op2 = '0; flush = 1'b0; md_done = 1'b0;
  endtask

  task automatic do_probe(input logic [7:0] pinst);
    probe_t p;
    ex_valid = 1'b1;
    inst     = pinst;
    p.hilo   = exp_hilo;
    p.mf     = (pinst == c_INST_MFHI) ? exp_hilo[63:32] :
               (pinst == c_INST_MFLO) ? exp_hilo[31:0] : 32'd0;
    p.to     = exp_to;
    p.mdop1  = exp_mdop1;
    probe_q.push_back(p);
    probe = 1'b1;
    tick();
    probe = 1'b0;
    idle_in();
  endtask

  task automatic push_start(input logic [7:0] i, input logic [31:0] a, input logic [31:0] b);
    start_t s;
    s.inst = i; s.op1 = a; s.op2 = b;
    start_q.push_back(s);
    exp_mdop1 = a;
  endtask

  // Issue in this cycle, md_done k cycles later, then the DONE cycle.
  task automatic do_muldiv(input logic [7:0] i, input logic [31:0] a, input logic [31:0] b,
                           input int k, input logic [63:0] res);
    ex_valid = 1'b1; inst = i; op1 = a; op2 = b;
    push_start(i, a, b);
    stall_q.push_back(k + 1);
    repeat (k) tick();
    md_done = 1'b1; md_result = res;
    tick();
    md_done  = 1'b0;
    exp_hilo = res;
    tick();
    idle_in();
  endtask

  initial begin : stimulus
    idle_in();
    md_result = '0;
    exp_hilo = '0; exp_to = 1'b0; exp_mdop1 = '0;
    repeat (2) tick();
    do_probe(c_INST_MFHI);
    rst_n = 1'b1;
    tick();

    do_muldiv(c_INST_MULT, 32'hFFFF_FFFE, 32'd3, 4, 64'hFFFF_FFFF_FFFF_FFFA);
    do_probe(c_INST_MFLO);
    do_probe(c_INST_MFHI);

    ex_valid = 1'b1; inst = c_INST_MTHI; op1 = 32'h1234_5678;
    tick();
    inst = c_INST_MTLO; op1 = 32'h9ABC_DEF0;
    tick();
    idle_in();
    exp_hilo = 64'h1234_5678_9ABC_DEF0;
    do_probe(c_INST_MFHI);
    do_probe(c_INST_MFLO);

    ex_valid = 1'b1; inst = c_INST_DIVU; op1 = 32'd7; op2 = 32'd0;
    repeat (3) tick();
    inst = c_INST_DIV;
    repeat (2) tick();
    idle_in();
    do_probe(c_INST_DIVU);
    do_probe(c_INST_MFLO);

    md_done = 1'b1; md_result = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    md_done = 1'b0;
    do_probe(c_INST_MFHI);

    ex_valid = 1'b1; flush = 1'b1; inst = c_INST_MTHI; op1 = 32'h0000_CAFE;
    tick();
    inst = c_INST_MULT; op1 = 32'd5; op2 = 32'd5;
    tick();
    idle_in();
    do_probe(c_INST_MFHI);

    ex_valid = 1'b1; inst = c_INST_DIV; op1 = 32'd100; op2 = 32'd7;
    push_start(c_INST_DIV, 32'd100, 32'd7);
    stall_q.push_back(3);
    repeat (3) tick();
    flush = 1'b1; md_done = 1'b1; md_result = 64'h1111_2222_3333_4444;
    abort_q.push_back(1'b0);
    tick();
    idle_in();
    do_probe(c_INST_MFLO);

    do_muldiv(c_INST_DIVU, 32'd100, 32'd7, 2, 64'h0000_0002_0000_000E);
    do_muldiv(c_INST_MULTU, 32'h0001_0000, 32'h0001_0000, 1, 64'h0000_0001_0000_0000);
    do_probe(c_INST_MFHI);

    ex_valid = 1'b1; inst = c_INST_MULTU; op1 = 32'd5; op2 = 32'd6;
    push_start(c_INST_MULTU, 32'd5, 32'd6);
    stall_q.push_back(65);
    abort_q.push_back(1'b1);
    repeat (65) tick();
    idle_in();
    exp_to = 1'b1;
    do_probe(c_INST_MFLO);

    ex_valid = 1'b1; inst = c_INST_MULT; op1 = 32'd3; op2 = 32'd4;
    push_start(c_INST_MULT, 32'd3, 32'd4);
    stall_q.push_back(2);
    repeat (2) tick();
    #1;
    rst_n = 1'b0;
    idle_in();
    exp_hilo = '0; exp_to = 1'b0; exp_mdop1 = '0;
    do_probe(c_INST_MFHI);
    rst_n = 1'b1;
    tick();
    do_muldiv(c_INST_MULT, 32'd2, 32'h10, 1, 64'h0000_0000_0000_0020);
    do_probe(c_INST_MFLO);

    repeat (3) tick();
    check("start_q_left", start_q.size(), 0);
    check("abort_q_left", abort_q.size(), 0);
    check("stall_q_left", stall_q.size(), 0);
    check("probe_q_left", probe_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_issue_ctrl.md
# mdu_issue_ctrl

Issuing side of the multi-cycle multiply/divide interface in the EX stage. Accepts decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the pipeline. Starts the multi-cycle arithmetic unit (mul_cycle) and stalls the pipeline until that unit reports done. Owns the architectural HI/LO register and handles exception flush mid-operation.

## Interface
- MAX_WAIT, 64: watchdog limit in cycles for a busy operation.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  EX holds a valid instruction this cycle.
- inst  in  8  decoded instruction code, `INST_* from defs.v.
- op1  in  32  rs operand.
- op2  in  32  rt operand.
- exception_flush  in  1  kill the in-flight operation.
- stall_req  out  1  hold IF/ID/EX; combinational.
- md_inst  out  8  instruction sent to the arithmetic unit; registered.
- md_op1  out  32  latched operand 1 for the arithmetic unit.
- md_op2  out  32  latched operand 2 for the arithmetic unit.
- md_start  out  1  one-cycle pulse that starts an operation.
- md_abort  out  1  one-cycle pulse that cancels an operation.
- md_result  in  64  {HI,LO} from the arithmetic unit.
- md_done  in  1  result valid; single-cycle pulse.
- hilo  out  64  current {HI,LO}.
- mf_result  out  32  value returned by MFHI/MFLO.
- md_timeout  out  1  sticky watchdog flag; cleared only by reset.

## Operation
- States: IDLE, BUSY, DONE.
- Reset values:
  - State is IDLE.
  - hilo = 0.
  - md_inst = 0.
  - md_op1 = 0 and md_op2 = 0.
  - md_start = 0 and md_abort = 0.
  - md_timeout = 0.
  - Wait counter = 0.
- IDLE, with ex_valid and a mul/div instruction and no flush:
  - Latch inst/op1/op2 into md_*.
  - Pulse md_start on the next cycle.
  - Go to BUSY.
  - stall_req = 1 in this same cycle.
- DIV/DIVU with op2 == 0:
  - No issue, no stall.
  - HI/LO unchanged.
- IDLE, MTHI with ex_valid: HI <= op1 at the clock edge.
- IDLE, MTLO with ex_valid: LO <= op1 at the clock edge.
- MFHI/MFLO:
  - mf_result = hilo[63:32] for MFHI, hilo[31:0] for MFLO, combinationally.
  - Zero for any other instruction.
- BUSY:
  - stall_req = 1.
  - The 6-bit-plus wait counter increments each cycle.
- BUSY, md_done:
  - hilo <= md_result.
  - Go to DONE.
  - stall_req stays 1 in the md_done cycle.
- DONE:
  - stall_req = 0 for exactly one cycle, so the pipeline advances past the instruction.
  - inst is ignored (no reissue of the same instruction).
  - Return to IDLE.
- exception_flush in BUSY:
  - Pulse md_abort and return to IDLE.
  - No HI/LO write.
  - stall_req = 0 in the flush cycle.
- Flush and md_done in the same cycle: flush wins, and the result is discarded.
- exception_flush in IDLE: suppresses issue and suppresses MTHI/MTLO writes.
- Wait counter reaches MAX_WAIT in BUSY:
  - Set md_timeout and pulse md_abort.
  - Go to IDLE.
  - HI/LO unchanged.
- md_done outside BUSY is ignored.
- Reset asserted mid-operation: immediate return to reset values; no md_abort pulse.

## Timing
- Issue latency: md_start is asserted in the cycle after acceptance (cycle N+1).
- For md_done in cycle N+k, the stall spans cycles N..N+k.
- hilo is updated at the end of cycle N+k and visible from N+k+1 (the DONE cycle).
- Back-to-back: a new mul/div can be accepted in the first IDLE cycle after DONE.
- No forwarding of md_result into mf_result during the md_done cycle.
  - The stall guarantees an MFHI/MFLO sees the updated hilo.

## Structure
- defs.v holds:
  - `INST_* codes (existing).
  - New state constants `MDU_IDLE/`MDU_BUSY/`MDU_DONE (2 bits).
- No sub-module is needed.
- The arithmetic unit (mul_cycle) is instantiated beside this block at the EX level, not inside it.
- The block is a single always-block FSM with the counter and HI/LO register, plus combinational stall/mf_result logic.

## Test plan
- MULT, op1=0xFFFFFFFE, op2=3, md_done after 4 cycles with md_result=0xFFFFFFFF_FFFFFFFA:
  - md_start pulses once.
  - stall_req is high for 5 cycles.
  - Then hilo = 0xFFFFFFFF_FFFFFFFA.
  - MFLO returns 0xFFFFFFFA.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 in IDLE:
  - hilo = 0x12345678_9ABCDEF0.
  - No stall.
- DIVU, op2=0:
  - No md_start.
  - stall_req stays 0.
  - hilo unchanged.
- DIV issued, exception_flush on BUSY cycle 3, md_done on cycle 3:
  - md_abort pulses.
  - State returns to IDLE.
  - hilo unchanged.
- MULTU issued, md_done never arrives:
  - After 64 BUSY cycles, md_timeout = 1 and md_abort pulses.
  - stall_req drops.
- rst_n asserted low mid-BUSY:
  - All outputs go to reset values asynchronously.
  - A subsequent MULT completes normally.
